// File: rtl/scn_pkg.sv
// scn_pkg: arbiter state encoding and default geometry for the scanline layer fetcher.
package scn_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DRAIN} arb_state_e;
  localparam int N_LAYERS_DEF = 3;
  localparam int TILE_WIDTH_DEF = 8;
  localparam int SLOTS_DEF = 4;
  localparam int QDEPTH_DEF = 2;
  localparam int ROM_AW_DEF = 21;
endpackage

// File: rtl/scn_tile_shifter.sv
// scn_tile_shifter: per-layer ring of tile rows and colour banks with a registered tap read.
module scn_tile_shifter
  import scn_pkg::*;
#(
  parameter int TILE_WIDTH = TILE_WIDTH_DEF,
  parameter int SLOTS = SLOTS_DEF,
  localparam int SW = $clog2(SLOTS),
  localparam int PW = $clog2(TILE_WIDTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ce_pixel,
  input  logic                    we,
  input  logic [SW-1:0]           wslot,
  input  logic                    wflip,
  input  logic [7:0]              wcolor,
  input  logic [TILE_WIDTH*4-1:0] wdata,
  input  logic [SW+PW-1:0]        tap,
  output logic [11:0]             dot
);
  logic [TILE_WIDTH*4-1:0] row_q [SLOTS], row_d [SLOTS];
  logic [7:0] color_q [SLOTS], color_d [SLOTS];
  logic [11:0] dot_q, dot_d;
  always_comb begin
    row_d = row_q;
    color_d = color_q;
    if (we) begin
      color_d[wslot] = wcolor;
      for (int i = 0; i < TILE_WIDTH; i++)
        row_d[wslot][i*4 +: 4] = wflip ? wdata[i*4 +: 4] : wdata[(TILE_WIDTH-1-i)*4 +: 4];
    end
    // reads the pre-write contents so a same-cycle write never shows through
    dot_d = {color_q[tap[SW+PW-1:PW]], row_q[tap[SW+PW-1:PW]][int'(tap[PW-1:0])*4 +: 4]};
  end
  always_ff @(posedge clk) begin
    if (reset) dot_q <= '0;
    else if (ce_pixel) dot_q <= dot_d;
    row_q <= row_d;
    color_q <= color_d;
  end
  assign dot = dot_q;
endmodule

// File: rtl/scn_layer_fetch.sv
// scn_layer_fetch: per-layer request queues, round-robin toggle-handshake ROM arbiter,
// tile rings and priority mixer.
module scn_layer_fetch
  import scn_pkg::*;
#(
  parameter int N_LAYERS = N_LAYERS_DEF,
  parameter int TILE_WIDTH = TILE_WIDTH_DEF,
  parameter int SLOTS = SLOTS_DEF,
  parameter int QDEPTH = QDEPTH_DEF,
  parameter int ROM_AW = ROM_AW_DEF,
  localparam int SW = $clog2(SLOTS),
  localparam int TW = $clog2(SLOTS) + $clog2(TILE_WIDTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ce_pixel,
  input  logic [N_LAYERS-1:0]      req_valid,
  output logic [N_LAYERS-1:0]      req_ready,
  input  logic [N_LAYERS*ROM_AW-1:0] req_addr,
  input  logic [N_LAYERS*8-1:0]    req_color,
  input  logic [N_LAYERS-1:0]      req_flip,
  input  logic [N_LAYERS*SW-1:0]   req_slot,
  output logic [ROM_AW-1:0]        rom_address,
  output logic                     rom_req,
  input  logic                     rom_ack,
  input  logic [TILE_WIDTH*4-1:0]  rom_data,
  input  logic [N_LAYERS*TW-1:0]   tap,
  input  logic [N_LAYERS-1:0]      layer_en,
  input  logic [N_LAYERS*2-1:0]    prio_order,
  output logic [N_LAYERS*12-1:0]   dot_out,
  output logic [11:0]              mix_dot,
  output logic [2:0]               mix_layer
);
  localparam int EW = ROM_AW + 9 + SW;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int QW = QDEPTH > 1 ? $clog2(QDEPTH) : 1;
  arb_state_e state_q, state_d;
  logic [1:0] grant_q, grant_d, last_q, last_d, g, idx, p;
  logic [ROM_AW-1:0] rom_address_q, rom_address_d;
  logic rom_req_q, rom_req_d, done, found;
  logic [EW-1:0] mem_q [N_LAYERS][QDEPTH], mem_d [N_LAYERS][QDEPTH], head [N_LAYERS];
  logic [QW-1:0] rd_q [N_LAYERS], rd_d [N_LAYERS], wr_q [N_LAYERS], wr_d [N_LAYERS];
  logic [CW-1:0] cnt_q [N_LAYERS], cnt_d [N_LAYERS];
  logic [N_LAYERS-1:0] push, pop, busy;
  logic [11:0] mix_dot_q, mix_dot_d;
  logic [2:0] mix_layer_q, mix_layer_d;

  function automatic logic [QW-1:0] wrap_inc(input logic [QW-1:0] v);
    return (int'(v) == QDEPTH - 1) ? '0 : v + 1'b1;
  endfunction

  assign push = req_valid & req_ready;
  assign done = state_q == ST_WAIT && rom_req_q == rom_ack && !reset;

  genvar l;
  for (l = 0; l < N_LAYERS; l++) begin : g_layer
    assign req_ready[l] = cnt_q[l] < CW'(QDEPTH);
    assign busy[l] = cnt_q[l] != '0;
    assign pop[l] = done && grant_q == 2'(l);
    assign head[l] = mem_q[l][rd_q[l]];
    scn_tile_shifter #(.TILE_WIDTH(TILE_WIDTH), .SLOTS(SLOTS)) u_shifter (
      .clk(clk), .reset(reset), .ce_pixel(ce_pixel), .we(pop[l]),
      .wslot(head[l][SW-1:0]), .wflip(head[l][SW]), .wcolor(head[l][SW+1 +: 8]),
      .wdata(rom_data), .tap(tap[l*TW +: TW]), .dot(dot_out[l*12 +: 12])
    );
  end

  // largest offset first so the nearest busy layer after last_grant wins
  always_comb begin
    g = last_q;
    idx = '0;
    for (int k = N_LAYERS; k >= 1; k--) begin
      idx = 2'((int'(last_q) + k) % N_LAYERS);
      if (busy[idx]) g = idx;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    rom_address_d = rom_address_q;
    rom_req_d = rom_req_q;
    mem_d = mem_q;
    rd_d = rd_q;
    wr_d = wr_q;
    cnt_d = cnt_q;
    case (state_q)
      ST_IDLE: if (|busy && rom_req_q == rom_ack && !reset) begin
        rom_address_d = head[g][EW-1 -: ROM_AW];
        rom_req_d = ~rom_req_q;
        grant_d = g;
        state_d = ST_WAIT;
      end
      ST_WAIT: if (done) begin
        last_d = grant_q;
        state_d = ST_IDLE;
      end
      ST_DRAIN: if (rom_req_q == rom_ack) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    for (int i = 0; i < N_LAYERS; i++) begin
      if (push[i]) begin
        mem_d[i][wr_q[i]] = {req_addr[i*ROM_AW +: ROM_AW], req_color[i*8 +: 8], req_flip[i], req_slot[i*SW +: SW]};
        wr_d[i] = wrap_inc(wr_q[i]);
      end
      if (pop[i]) rd_d[i] = wrap_inc(rd_q[i]);
      cnt_d[i] = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
    end
  end

  always_comb begin
    mix_dot_d = '0;
    mix_layer_d = 3'(N_LAYERS);
    found = 1'b0;
    p = '0;
    for (int i = 0; i < N_LAYERS; i++) begin
      p = prio_order[i*2 +: 2];
      if (!found && int'(p) < N_LAYERS && layer_en[p] && dot_out[int'(p)*12 +: 4] != '0) begin
        found = 1'b1;
        mix_dot_d = dot_out[int'(p)*12 +: 12];
        mix_layer_d = {1'b0, p};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // an open ROM transaction survives reset and must be drained before reuse
      state_q <= (rom_req_q != rom_ack) ? ST_DRAIN : ST_IDLE;
      grant_q <= '0;
      last_q <= 2'(N_LAYERS - 1);
      rom_address_q <= '0;
      rd_q <= '{default: '0};
      wr_q <= '{default: '0};
      cnt_q <= '{default: '0};
      mix_dot_q <= '0;
      mix_layer_q <= 3'(N_LAYERS);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      rom_address_q <= rom_address_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
      if (ce_pixel) begin
        mix_dot_q <= mix_dot_d;
        mix_layer_q <= mix_layer_d;
      end
    end
    rom_req_q <= rom_req_d;
    mem_q <= mem_d;
  end

  assign rom_address = rom_address_q;
  assign rom_req = rom_req_q;
  assign mix_dot = mix_dot_q;
  assign mix_layer = mix_layer_q;
endmodule

// File: tb/tb_scn_layer_fetch.sv
// tb_scn_layer_fetch: directed checks of queueing, ROM arbitration, drain-on-reset, tap reads and mixing.
module tb_scn_layer_fetch;
  logic clk, reset, ce_pixel, rom_req, rom_ack;
  logic [2:0] req_valid, req_ready, req_flip, layer_en, mix_layer;
  logic [62:0] req_addr;
  logic [23:0] req_color;
  logic [5:0] req_slot, prio_order;
  logic [20:0] rom_address;
  logic [31:0] rom_data;
  logic [14:0] tap;
  logic [35:0] dot_out;
  logic [11:0] mix_dot, d;
  int errors = 0, checks = 0;

  scn_layer_fetch dut (
    .clk(clk), .reset(reset), .ce_pixel(ce_pixel), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_color(req_color), .req_flip(req_flip), .req_slot(req_slot),
    .rom_address(rom_address), .rom_req(rom_req), .rom_ack(rom_ack), .rom_data(rom_data),
    .tap(tap), .layer_en(layer_en), .prio_order(prio_order), .dot_out(dot_out),
    .mix_dot(mix_dot), .mix_layer(mix_layer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int l, input logic [20:0] a, input logic [7:0] c, input logic f, input logic [1:0] s);
    req_addr[l*21 +: 21] = a;
    req_color[l*8 +: 8] = c;
    req_flip[l] = f;
    req_slot[l*2 +: 2] = s;
    req_valid[l] = 1'b1;
  endtask

  task automatic serve(input string tag, input logic [20:0] exp_addr, input logic [31:0] data);
    int n = 0;
    while (rom_req === rom_ack && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_open"}, 32'(rom_req !== rom_ack), 32'd1);
    chk({tag, "_addr"}, 32'(rom_address), 32'(exp_addr));
    tick();
    rom_data = data;
    rom_ack = rom_req;
    tick();
  endtask

  task automatic read_dot(input int l, input logic [1:0] s, input logic [2:0] px, output logic [11:0] o);
    tap[l*5 +: 5] = {s, px};
    ce_pixel = 1'b1;
    tick();
    ce_pixel = 1'b0;
    o = dot_out[l*12 +: 12];
  endtask

  task automatic mix_run;
    ce_pixel = 1'b1;
    tick();
    tick();
    ce_pixel = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ce_pixel = 1'b0; req_valid = '0; req_addr = '0; req_color = '0;
    req_flip = '0; req_slot = '0; rom_data = '0; tap = '0; layer_en = '0; prio_order = 6'b10_01_00;
    rom_ack = 1'b0;
    #1 rom_ack = rom_req;
    repeat (3) tick();
    chk("rst_mix_layer", 32'(mix_layer), 32'd3);
    chk("rst_mix_dot", 32'(mix_dot), 32'd0);
    chk("rst_dot_out", 32'(dot_out[31:0]), 32'd0);
    chk("rst_rom_addr", 32'(rom_address), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd7);
    reset = 1'b0;

    // flip=0 reverses nibbles; taps 8..15 walk slot 1
    set_req(0, 21'h00100, 8'h5A, 1'b0, 2'd1);
    tick();
    req_valid = '0;
    serve("t1", 21'h00100, 32'h76543210);
    layer_en = 3'b001;
    ce_pixel = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tap[4:0] = {2'd1, 3'(i)};
      tick();
      chk($sformatf("t1_dot%0d", i), 32'(dot_out[11:0]), {20'd0, 8'h5A, 4'(7 - i)});
      if (i > 0) chk($sformatf("t1_mix%0d", i), 32'(mix_dot), {20'd0, 8'h5A, 4'(8 - i)});
      if (i == 1) chk("t1_mix_layer", 32'(mix_layer), 32'd0);
    end
    tick();
    ce_pixel = 1'b0;
    chk("t1_transparent_layer", 32'(mix_layer), 32'd3);
    chk("t1_transparent_dot", 32'(mix_dot), 32'd0);

    // simultaneous requests after reset grant 0,1,2
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_req(0, 21'h01000, 8'h55, 1'b1, 2'd0);
    set_req(1, 21'h02000, 8'h11, 1'b1, 2'd2);
    set_req(2, 21'h03000, 8'h44, 1'b1, 2'd3);
    tick();
    req_valid = '0;
    serve("rr0", 21'h01000, 32'h11111111);
    serve("rr1", 21'h02000, 32'h89ABCDEF);
    serve("rr2", 21'h03000, 32'h0FEDCBA0);
    set_req(1, 21'h04000, 8'h33, 1'b1, 2'd0);
    tick();
    req_valid = '0;
    serve("rr_l1", 21'h04000, 32'h000000F0);
    read_dot(1, 2'd2, 3'd0, d);
    chk("flip1_px0", 32'(d), 32'h11F);
    read_dot(1, 2'd2, 3'd7, d);
    chk("flip1_px7", 32'(d), 32'h118);

    // queue full with the ROM stalled
    set_req(2, 21'h07001, 8'h66, 1'b1, 2'd1);
    tick();
    req_addr[62:42] = 21'h07002;
    tick();
    chk("q_full", 32'(req_ready[2]), 32'd0);
    req_addr[62:42] = 21'h07003;
    tick();
    tick();
    chk("q_full_held", 32'(req_ready[2]), 32'd0);
    serve("q1", 21'h07001, 32'h00000001);
    chk("q_ready_after_pop", 32'(req_ready[2]), 32'd1);
    tick();
    req_valid = '0;
    chk("q_refull", 32'(req_ready[2]), 32'd0);
    serve("q2", 21'h07002, 32'h00000002);
    serve("q3", 21'h07003, 32'h00000003);
    chk("q_all_ready", 32'(req_ready), 32'd7);

    // reset mid-transaction drains the stale ack without writing
    set_req(0, 21'h05000, 8'h22, 1'b1, 2'd3);
    tick();
    req_valid = '0;
    serve("pre", 21'h05000, 32'h12345678);
    read_dot(0, 2'd3, 3'd0, d);
    chk("pre_px0", 32'(d), 32'h228);
    set_req(0, 21'h05100, 8'h99, 1'b0, 2'd3);
    tick();
    req_valid = '0;
    tick();
    chk("drain_open", 32'(rom_req !== rom_ack), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("drain_req_kept", 32'(rom_req !== rom_ack), 32'd1);
    chk("drain_rom_addr", 32'(rom_address), 32'd0);
    chk("drain_dot_rst", 32'(dot_out[11:0]), 32'd0);
    chk("drain_mix_rst", 32'(mix_layer), 32'd3);
    repeat (4) tick();
    rom_data = 32'hFFFFFFFF;
    rom_ack = rom_req;
    repeat (3) tick();
    chk("drain_no_reissue", 32'(rom_req !== rom_ack), 32'd0);
    read_dot(0, 2'd3, 3'd0, d);
    chk("drain_no_write", 32'(d), 32'h228);
    set_req(0, 21'h06000, 8'h77, 1'b1, 2'd3);
    tick();
    req_valid = '0;
    serve("post", 21'h06000, 32'h0000000A);
    read_dot(0, 2'd3, 3'd0, d);
    chk("post_px0", 32'(d), 32'h77A);

    // priority mixing: entries listed from entry 0 in the low bits
    tap = {2'd3, 3'd1, 2'd0, 3'd0, 2'd1, 3'd5};
    layer_en = 3'b111;
    prio_order = {2'd2, 2'd0, 2'd1};
    mix_run();
    chk("mixA_layer", 32'(mix_layer), 32'd0);
    chk("mixA_dot", 32'(mix_dot), 32'h5A2);
    layer_en = 3'b110;
    mix_run();
    chk("mixB_layer", 32'(mix_layer), 32'd2);
    chk("mixB_dot", 32'(mix_dot), 32'h44A);
    tap[14:10] = {2'd3, 3'd0};
    mix_run();
    chk("mixC_layer", 32'(mix_layer), 32'd3);
    chk("mixC_dot", 32'(mix_dot), 32'd0);
    tap[14:10] = {2'd3, 3'd1};
    layer_en = 3'b111;
    prio_order = {2'd0, 2'd2, 2'd3};
    mix_run();
    chk("mixD_skip3", 32'(mix_layer), 32'd2);
    tap[9:5] = {2'd0, 3'd1};
    prio_order = {2'd1, 2'd1, 2'd1};
    mix_run();
    chk("mixE_dup_layer", 32'(mix_layer), 32'd1);
    chk("mixE_dup_dot", 32'(mix_dot), 32'h33F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
